// File: rtl/cart_io_sequencer.sv
// cart_io_sequencer: console-side controller for the cartridge mapper bus.
// After reset it unlocks the mapper (5Ah, A5h), checks the 18-bit SO sync
// stream, then arbitrates two requesters onto timed I/O-register bus cycles.
//
// Handshake: a requester raises REQx with WEx/Ax/WDx stable and holds them
// until it sees the one-cycle ACKx pulse; RD and ERR are valid only while
// ACKx is high. The cycle in which ACKx is high never starts a new grant for
// that same requester, so a held REQ is not mistaken for a second request.
module cart_io_sequencer #(
  parameter int          WAIT_CYC  = 2,
  parameter logic [17:0] SYNC_PAT  = 18'h05140,
  parameter bit          UNLOCK_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       WE0,
  input  logic       WE1,
  input  logic [7:0] A0,
  input  logic [7:0] A1,
  input  logic [7:0] WD0,
  input  logic [7:0] WD1,
  output logic       ACK0,
  output logic       ACK1,
  output logic [7:0] RD,
  output logic       ERR,
  output logic       READY,
  output logic       FAIL,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] DQ_O,
  output logic       DQ_OE,
  input  logic [7:0] DQ_I,
  output logic       SSn,
  output logic       CEn,
  output logic       OEn,
  output logic       WEn,
  input  logic       SO,
  output logic [3:0] DBG_STATE
);

  localparam logic [3:0] ST_RST_W  = 4'd0;
  localparam logic [3:0] ST_UNLK_A = 4'd1;
  localparam logic [3:0] ST_UNLK_N = 4'd2;
  localparam logic [3:0] ST_SYNC   = 4'd3;
  localparam logic [3:0] ST_READY  = 4'd4;
  localparam logic [3:0] ST_FAIL   = 4'd5;
  localparam logic [3:0] ST_SETUP  = 4'd6;
  localparam logic [3:0] ST_STROBE = 4'd7;
  localparam logic [3:0] ST_HOLD   = 4'd8;

  localparam logic [3:0] STRB_LOAD = 4'(WAIT_CYC - 1);

  logic [3:0]  state;
  logic [3:0]  strb_cnt;
  logic [4:0]  sync_cnt;
  logic [17:0] sync_sh;
  logic [17:0] sync_next;
  logic        gnt;       // requester owning the current bus cycle
  logic        last_gnt;  // requester granted most recently
  logic        we_r;
  logic        req0_v;
  logic        req1_v;
  logic        pick1;

  assign DBG_STATE = state;

  // A requester is ignored during its own ACK cycle (REQ not yet dropped).
  assign req0_v = REQ0 & ~ACK0;
  assign req1_v = REQ1 & ~ACK1;

  // Round-robin: lone requester wins; on contention the one not granted last.
  assign pick1 = req1_v & (~req0_v | ~last_gnt);

  // SO arrives LSB first, so each new sample enters at the top.
  assign sync_next = {SO, sync_sh[17:1]};

  // Sequencer FSM with all bus outputs registered alongside it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_RST_W;
      strb_cnt <= 4'd0;
      sync_cnt <= 5'd0;
      sync_sh  <= 18'd0;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;   // makes requester 0 win the first contention
      we_r     <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      ERR      <= 1'b0;
      RD       <= 8'h00;
      READY    <= 1'b0;
      FAIL     <= 1'b0;
      BUS_ADDR <= 8'h00;
      DQ_O     <= 8'h00;
      DQ_OE    <= 1'b0;
      SSn      <= 1'b1;
      CEn      <= 1'b1;
      OEn      <= 1'b1;
      WEn      <= 1'b1;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        ST_RST_W: begin
          if (UNLOCK_EN) begin
            state    <= ST_UNLK_A;
            BUS_ADDR <= 8'h5A;
          end else begin
            state <= ST_READY;
            READY <= 1'b1;
          end
        end
        ST_UNLK_A: begin
          state    <= ST_UNLK_N;
          BUS_ADDR <= 8'hA5;
        end
        ST_UNLK_N: begin
          state    <= ST_SYNC;
          BUS_ADDR <= 8'h00;
          sync_cnt <= 5'd0;
          sync_sh  <= 18'd0;
        end
        ST_SYNC: begin
          sync_sh  <= sync_next;
          sync_cnt <= sync_cnt + 5'd1;
          if (sync_cnt == 5'd17) begin
            if (sync_next == SYNC_PAT) begin
              state <= ST_READY;
              READY <= 1'b1;
            end else begin
              state <= ST_FAIL;
              FAIL  <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (req0_v || req1_v) begin
            state    <= ST_SETUP;
            gnt      <= pick1;
            last_gnt <= pick1;
            we_r     <= pick1 ? WE1 : WE0;
            BUS_ADDR <= pick1 ? A1 : A0;
            SSn      <= 1'b0;
            if (pick1 ? WE1 : WE0) begin
              DQ_O  <= pick1 ? WD1 : WD0;
              DQ_OE <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          state    <= ST_STROBE;
          strb_cnt <= STRB_LOAD;
          if (we_r) WEn <= 1'b0;
          else      OEn <= 1'b0;
        end
        ST_STROBE: begin
          if (strb_cnt == 4'd0) begin
            state <= ST_HOLD;
            OEn   <= 1'b1;
            WEn   <= 1'b1;
            if (!we_r) RD <= DQ_I;
          end else begin
            strb_cnt <= strb_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          state    <= ST_READY;
          SSn      <= 1'b1;
          DQ_OE    <= 1'b0;
          DQ_O     <= 8'h00;
          BUS_ADDR <= 8'h00;
          if (gnt) ACK1 <= 1'b1;
          else     ACK0 <= 1'b1;
        end
        ST_FAIL: begin
          // Refuse every request without touching the bus.
          if (req0_v) begin
            ACK0 <= 1'b1;
            ERR  <= 1'b1;
          end
          if (req1_v) begin
            ACK1 <= 1'b1;
            ERR  <= 1'b1;
          end
        end
        default: state <= ST_RST_W;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_io_sequencer.sv
// tb_cart_io_sequencer: directed bench for cart_io_sequencer (WAIT_CYC=2).
module tb_cart_io_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [7:0] A0 = 8'h00, A1 = 8'h00, WD0 = 8'h00, WD1 = 8'h00;
  logic       ACK0, ACK1, ERR, READY, FAIL, DQ_OE, SSn, CEn, OEn, WEn;
  logic [7:0] RD, BUS_ADDR, DQ_O;
  logic [7:0] DQ_I = 8'h00;
  logic       SO = 1'b0;
  logic [3:0] dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] exp_q[$];

  cart_io_sequencer #(.WAIT_CYC(2), .SYNC_PAT(18'h05140), .UNLOCK_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .A0(A0), .A1(A1), .WD0(WD0), .WD1(WD1),
    .ACK0(ACK0), .ACK1(ACK1), .RD(RD), .ERR(ERR),
    .READY(READY), .FAIL(FAIL),
    .BUS_ADDR(BUS_ADDR), .DQ_O(DQ_O), .DQ_OE(DQ_OE), .DQ_I(DQ_I),
    .SSn(SSn), .CEn(CEn), .OEn(OEn), .WEn(WEn), .SO(SO),
    .DBG_STATE(dbg_state)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and sample 1 ns later
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // RST must be high on entry; checks reset values, then runs the unlock/sync
  // sequence with the mapper SO model, optionally with sample 5 flipped.
  task automatic run_unlock(input bit flip5);
    logic [17:0] pat;
    bit strb_low;
    bit ack_seen;
    pat = 18'h05140;
    if (flip5) pat[5] = ~pat[5];
    strb_low = 1'b0;
    ack_seen = 1'b0;
    SO = 1'b0;
    #1;
    chk("rst_strobes", {SSn, CEn, OEn, WEn}, 4'b1111);
    chk("rst_addr", BUS_ADDR, 8'h00);
    chk("rst_dq", {DQ_OE, DQ_O}, 9'h000);
    chk("rst_flags", {ACK0, ACK1, ERR, READY, FAIL}, 5'b00000);
    chk("rst_rd", RD, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      tick();
      if (!SSn || !OEn || !WEn || !CEn) strb_low = 1'b1;
      if (ACK0 || ACK1) ack_seen = 1'b1;
      if (e == 1) chk("unlk_5a", BUS_ADDR, 8'h5A);
      if (e == 2) chk("unlk_a5", BUS_ADDR, 8'hA5);
      if (e == 3) chk("unlk_idle", BUS_ADDR, 8'h00);
      if (e == 20) chk("sync_early", {READY, FAIL}, 2'b00);
      if (e == 21) chk("sync_result", {READY, FAIL}, flip5 ? 2'b01 : 2'b10);
      // value driven after edge e is sampled at edge e+1 (sample e-3)
      if (e >= 3 && e <= 20) SO = pat[e-3];
    end
    SO = 1'b0;
    chk("unlk_strobes_high", strb_low, 1'b0);
    chk("unlk_no_ack", ack_seen, 1'b0);
  endtask

  task automatic set_req(input int p, input bit v, input bit we, input logic [7:0] addr,
                         input logic [7:0] wd);
    if (p == 0) begin
      REQ0 = v; WE0 = we; A0 = addr; WD0 = wd;
    end else begin
      REQ1 = v; WE1 = we; A1 = addr; WD1 = wd;
    end
  endtask

  // One access from READY. REQ goes up mid-cycle, so the edge that sees it is
  // tick 1 and the ACK (WAIT_CYC+2 = 4 edges later) shows at tick 5.
  task automatic do_access(input int p, input bit we, input logic [7:0] addr,
                           input logic [7:0] wd, input logic [7:0] dqi);
    int lat;
    int we_low;
    int oe_low;
    bit got;
    lat = 0; we_low = 0; oe_low = 0; got = 1'b0;
    DQ_I = dqi;
    set_req(p, 1'b1, we, addr, wd);
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (!WEn) we_low++;
      if (!OEn) oe_low++;
      if (lat == 1) begin
        chk("setup_bus", {SSn, BUS_ADDR}, {1'b0, addr});
        chk("setup_oe", DQ_OE, we);
      end
      if (lat == 4) begin
        chk("hold_strb", {SSn, OEn, WEn}, 3'b011);
        chk("hold_addr", BUS_ADDR, addr);
        if (we) chk("hold_dq", {DQ_OE, DQ_O}, {1'b1, wd});
      end
      if (ACK0 || ACK1) got = 1'b1;
    end
    chk("ack_latency", lat, 5);
    chk("ack_port", {ACK1, ACK0}, (p == 0) ? 2'b01 : 2'b10);
    chk("ack_err", ERR, 1'b0);
    if (!we) chk("ack_rd", RD, dqi);
    chk("we_low_cycles", we_low, we ? 2 : 0);
    chk("oe_low_cycles", oe_low, we ? 0 : 2);
    set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("ack_pulse", {ACK0, ACK1}, 2'b00);
    chk("idle_bus", {SSn, DQ_OE, BUS_ADDR}, {1'b1, 1'b0, 8'h00});
  endtask

  // Both requesters held: grants must alternate 0,1,0,1 starting with 0.
  task automatic alternate();
    int cyc;
    int acks;
    bit prev_ack;
    logic [7:0] want;
    exp_q.delete();
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    cyc = 0; acks = 0; prev_ack = 1'b0;
    DQ_I = 8'h5C;
    set_req(0, 1'b1, 1'b1, 8'hC0, 8'h11);
    set_req(1, 1'b1, 1'b0, 8'hCC, 8'h00);
    while (exp_q.size() != 0 && cyc < 80) begin
      tick();
      cyc++;
      if (ACK0 || ACK1) begin
        want = exp_q.pop_front();
        acks++;
        chk("alt_one_ack", ACK0 & ACK1, 1'b0);
        chk("alt_order", {7'd0, ACK1}, want);
        chk("alt_gap", {SSn, prev_ack}, 2'b10);
        if (ACK1) chk("alt_rd", RD, 8'h5C);
        if (acks == 4) begin
          set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
          set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        end
      end
      prev_ack = ACK0 | ACK1;
    end
    chk("alt_pending", exp_q.size(), 0);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("alt_settle", {ACK0, ACK1, SSn}, 3'b001);
  endtask

  // Reset asserted while a write is strobing.
  task automatic reset_mid_strobe();
    set_req(0, 1'b1, 1'b1, 8'hC3, 8'h55);
    tick();
    tick();
    chk("mid_strobe_wen", WEn, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_bus", {WEn, DQ_OE, SSn, ACK0}, 4'b1010);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("abort_no_ack", ACK0, 1'b0);
  endtask

  // In FAIL a request is refused with ERR and the bus never moves.
  task automatic fail_request();
    int lat;
    bit got;
    bit bus_moved;
    lat = 0; got = 1'b0; bus_moved = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'hC2, 8'h3F);
    while (!got && lat < 5) begin
      tick();
      lat++;
      if (!SSn || !OEn || !WEn || DQ_OE || BUS_ADDR != 8'h00) bus_moved = 1'b1;
      if (ACK0) got = 1'b1;
    end
    chk("fail_ack", {got, ERR}, 2'b11);
    chk("fail_ack_latency", lat, 1);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) begin
      tick();
      if (!SSn || !OEn || !WEn || DQ_OE) bus_moved = 1'b1;
    end
    chk("fail_no_bus", bus_moved, 1'b0);
    chk("fail_sticky", {FAIL, READY, ACK0}, 3'b100);
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) tick();
    run_unlock(1'b0);
    do_access(0, 1'b1, 8'hC1, 8'h07, 8'h00);
    do_access(1, 1'b0, 8'hCD, 8'h00, 8'h0A);
    alternate();
    reset_mid_strobe();
    run_unlock(1'b0);
    do_access(1, 1'b0, 8'hC0, 8'h00, 8'h3C);
    RST = 1'b1;
    tick();
    run_unlock(1'b1);
    fail_request();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // overall watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
